// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity bit, then one or two stop bits. The line idles high.
//
// Handshake: a word is accepted on any rising edge where tx_valid && tx_ready.
// tx_ready is high only in IDLE. tx_data is sampled on that edge only. A
// tx_valid seen while a frame is in progress is ignored and never queued.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 2500,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done,
  output logic [3:0]           bit_idx,
  output logic [2:0]           o_state
);

  localparam int FRAME_BITS = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int CNT_W      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST  = 4'(DATA_BITS);
  localparam logic [3:0] FRAME_LAST = 4'(FRAME_BITS - 1);

  // Refuse to elaborate with parameter values the datapath is not sized for.
  generate
    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $error("uart_tx_param: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_baud;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic [3:0]           r_bit_idx;

  logic                 w_bit_end;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_parity;

  assign w_bit_end   = (r_baud == BAUD_LAST);
  assign w_shift_nxt = r_shift >> 1;
  // Odd parity inverts the XOR so the total count of ones comes out odd.
  assign w_parity    = (PARITY == 1) ? ~(^tx_data) : (^tx_data);

  // Frame sequencer: state, baud counter, shift register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bit_idx <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) begin
        r_baud <= w_bit_end ? '0 : r_baud + CNT_W'(1);
      end
      unique case (r_state)
        S_IDLE: begin
          r_tx      <= 1'b1;
          r_ready   <= 1'b1;
          r_busy    <= 1'b0;
          r_bit_idx <= '0;
          r_baud    <= '0;
          if (tx_valid && r_ready) begin
            r_shift  <= tx_data;
            r_parity <= w_parity;
            r_state  <= S_START;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
            r_ready  <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
            r_bit_idx <= r_bit_idx + 4'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_bit_idx <= r_bit_idx + 4'd1;
            r_shift   <= w_shift_nxt;
            if (r_bit_idx == DATA_LAST) begin
              if (PARITY != 0) begin
                r_state <= S_PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_tx <= w_shift_nxt[0];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state   <= S_STOP;
            r_tx      <= 1'b1;
            r_bit_idx <= r_bit_idx + 4'd1;
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_bit_end) begin
            if (r_bit_idx == FRAME_LAST) begin
              // Last cycle of the final stop bit: first IDLE cycle flags completion.
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_ready   <= 1'b1;
              r_done    <= 1'b1;
              r_bit_idx <= '0;
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign tx_ready = r_ready;
  assign busy     = r_busy;
  assign tx_done  = r_done;
  assign bit_idx  = r_bit_idx;
  assign o_state  = r_state;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five instances with different parameter sets share
// one driver; sel picks which instance gets tx_valid and which one is observed.
module tb_uart_tx_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int         sel = 0;
  logic       drv_valid = 1'b0;
  logic [8:0] drv_data = '0;

  logic [4:0] v_w, tx_w, busy_w, ready_w, done_w;
  logic [3:0] idx_w [5];
  logic [2:0] st_w  [5];

  assign v_w = drv_valid ? (5'd1 << sel) : 5'd0;

  // instance parameter sets: 0 8N1, 1 8E1, 2 8O1, 3 7N2 (all 4 clk/bit), 4 defaults
  int cfg_cpb   [5] = '{4, 4, 4, 4, 2500};
  int cfg_dbits [5] = '{8, 8, 8, 7, 8};
  int cfg_par   [5] = '{0, 2, 1, 0, 0};
  int cfg_stop  [5] = '{1, 1, 1, 2, 1};

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(drv_data[7:0]), .tx_valid(v_w[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]),
    .bit_idx(idx_w[0]), .o_state(st_w[0]));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .tx_data(drv_data[7:0]), .tx_valid(v_w[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]),
    .bit_idx(idx_w[1]), .o_state(st_w[1]));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .tx_data(drv_data[7:0]), .tx_valid(v_w[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]),
    .bit_idx(idx_w[2]), .o_state(st_w[2]));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .tx_data(drv_data[6:0]), .tx_valid(v_w[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]),
    .bit_idx(idx_w[3]), .o_state(st_w[3]));
  uart_tx_param dut_d (
    .clk(clk), .rst_n(rst_n), .tx_data(drv_data[7:0]), .tx_valid(v_w[4]),
    .tx_ready(ready_w[4]), .tx(tx_w[4]), .busy(busy_w[4]), .tx_done(done_w[4]),
    .bit_idx(idx_w[4]), .o_state(st_w[4]));

  // ---------------- scoreboard ----------------
  // expected word per bit period: {tx, bit_idx[3:0], busy, ready, done}
  localparam logic [7:0] IDLE_V = 8'b1_0000_0_1_0;
  localparam logic [7:0] DONE_V = 8'b1_0000_0_1_1;

  logic [7:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int         k;
    logic [8:0] data;
    logic       par;
  } vec_t;
  vec_t vecs[11];

  function automatic logic [7:0] obs(input int k);
    return {tx_w[k], idx_w[k], busy_w[k], ready_w[k], done_w[k]};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b (tx,idx4,busy,ready,done) t=%0t", name, act, exp, $time);
  endtask

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic push_frame(input int k, input logic [8:0] d, input logic p);
    logic [3:0] idx;
    idx = 4'd0;
    exp_q.push_back({1'b0, idx, 3'b100});
    for (int i = 0; i < cfg_dbits[k]; i++) begin
      idx = idx + 4'd1;
      exp_q.push_back({d[i], idx, 3'b100});
    end
    if (cfg_par[k] != 0) begin
      idx = idx + 4'd1;
      exp_q.push_back({p, idx, 3'b100});
    end
    for (int s = 0; s < cfg_stop[k]; s++) begin
      idx = idx + 4'd1;
      exp_q.push_back({1'b1, idx, 3'b100});
    end
  endtask

  task automatic start_frame(input int k, input logic [8:0] d);
    sel       = k;
    drv_data  = d;
    drv_valid = 1'b1;
    @(negedge clk);
    drv_valid = 1'b0;
  endtask

  // pops one bit per period and compares it on every cycle of that period
  task automatic run_frame(input int k, input string name);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int c = 0; c < cfg_cpb[k]; c++) begin
        check(name, obs(k), e);
        @(negedge clk);
      end
    end
  endtask

  task automatic check_done(input int k, input string name);
    check({name, "_done"}, obs(k), DONE_V);
    @(negedge clk);
    check({name, "_idle"}, obs(k), IDLE_V);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [8:0] d;

    vecs[0] = '{0, 9'h0A5, 1'b0};
    vecs[1] = '{1, 9'h0A5, 1'b0};
    vecs[2] = '{2, 9'h0A5, 1'b1};
    vecs[3] = '{2, 9'h001, 1'b0};
    vecs[4] = '{3, 9'h041, 1'b0};
    for (int i = 5; i < 11; i++) begin
      d = 9'($urandom_range(0, 255));
      vecs[i].k    = 1 + (i % 2);
      vecs[i].data = d;
      vecs[i].par  = (vecs[i].k == 1) ? (^d[7:0]) : ~(^d[7:0]);
    end

    // reset state of every instance
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("reset_outputs", obs(k), IDLE_V);
      check("reset_state", {5'd0, st_w[k]}, 8'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven frames: 8N1, even/odd parity, 7N2, random parity words
    for (int i = 0; i < 11; i++) begin
      push_frame(vecs[i].k, vecs[i].data, vecs[i].par);
      start_frame(vecs[i].k, vecs[i].data);
      run_frame(vecs[i].k, "table_frame");
      check_done(vecs[i].k, "table_frame");
    end

    // back-to-back with tx_valid held high; data changed during the first frame
    sel = 0;
    push_frame(0, 9'h055, 1'b0);
    drv_data  = 9'h055;
    drv_valid = 1'b1;
    @(negedge clk);
    drv_data = 9'h0AA;
    run_frame(0, "b2b_first");
    check("b2b_gap_done", obs(0), DONE_V);
    push_frame(0, 9'h0AA, 1'b0);
    @(negedge clk);
    drv_valid = 1'b0;
    fork
      run_frame(0, "b2b_second");
      begin
        for (int j = 0; j < 6; j++) begin
          repeat (2) @(negedge clk);
          drv_valid = 1'b1;
          drv_data  = 9'($urandom_range(0, 255));
          @(negedge clk);
          drv_valid = 1'b0;
        end
      end
    join
    check_done(0, "b2b_second");
    check("b2b_not_queued", obs(0), IDLE_V);

    // reset in the middle of data bit 4 aborts at once, without tx_done
    start_frame(0, 9'h03C);
    repeat (16) @(negedge clk);
    check("abort_at_bit4", obs(0), {1'b1, 4'd4, 3'b100});
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_immediate", obs(0), IDLE_V);
    @(negedge clk);
    check("abort_held", obs(0), IDLE_V);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_released", obs(0), IDLE_V);
    push_frame(0, 9'h0C3, 1'b0);
    start_frame(0, 9'h0C3);
    run_frame(0, "after_abort");
    check_done(0, "after_abort");

    // default bit period: 0x00 frame, 25000 cycles on the line
    push_frame(4, 9'h000, 1'b0);
    start_frame(4, 9'h000);
    run_frame(4, "slow_frame");
    check_done(4, "slow_frame");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
